// File: rtl/serial_frame_pkg.sv
// Shared types and sizing helpers for the serial frame receiver.
package serial_frame_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DATA   = 3'd1,
    PARITY = 3'd2,
    STOP   = 3'd3,
    RESYNC = 3'd4
  } state_t;

  localparam int DEF_DATA_W = 8;

  function automatic int cnt_width(input int data_w);
    return $clog2(data_w + 1);
  endfunction

  // Start-bit sample to dout_valid, in clocks.
  function automatic int frame_len(input int data_w, input int parity_en);
    return 2 + data_w + parity_en;
  endfunction

endpackage

// File: rtl/serial_frame_obuf.sv
// Single-entry output holding register; a write lands 1 clock later.
// A write is dropped and overrun pulses if the entry is full and not being accepted.
module serial_frame_obuf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  output logic [W-1:0] dout,
  output logic         dout_valid,
  input  logic         dout_ready,
  output logic         overrun
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (wr_en) begin
        if (!dout_valid || dout_ready) begin
          dout       <= wr_data;
          dout_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (dout_valid && dout_ready) begin
        dout_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/serial_frame_rx.sv
// Deserialises start/data(LSB first)/parity/stop frames into words, 2+DATA_W+PARITY_EN clocks
// from start bit to dout_valid; words arriving while the holding register is stalled are dropped.
module serial_frame_rx
  import serial_frame_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter bit PARITY_EN  = 1'b1,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              parity_err,
  output logic              framing_err,
  output logic              overrun,
  output logic              busy
);

  localparam int CNT_W = cnt_width(DATA_W);

  state_t            state, state_nx;
  logic [DATA_W-1:0] shreg;
  logic [CNT_W-1:0]  cnt;
  logic              acc;
  logic              bad;
  logic              wr_en;
  logic              perr_nx;
  logic              ferr_nx;

  always_comb begin
    state_nx = state;
    wr_en    = 1'b0;
    perr_nx  = 1'b0;
    ferr_nx  = 1'b0;
    case (state)
      IDLE:   if (!din) state_nx = DATA;
      DATA:   if (cnt == CNT_W'(DATA_W - 1)) state_nx = PARITY_EN ? PARITY : STOP;
      PARITY: state_nx = STOP;
      STOP: begin
        if (din) begin
          state_nx = IDLE;
          if (bad) perr_nx = 1'b1;
          else     wr_en   = 1'b1;
        end else begin
          // A low stop bit reports only the framing error, never parity.
          state_nx = RESYNC;
          ferr_nx  = 1'b1;
        end
      end
      RESYNC: if (din) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      shreg       <= '0;
      cnt         <= '0;
      acc         <= 1'b0;
      bad         <= 1'b0;
      parity_err  <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      state       <= state_nx;
      parity_err  <= perr_nx;
      framing_err <= ferr_nx;
      case (state)
        IDLE: if (!din) begin
          cnt <= '0;
          acc <= PARITY_ODD;
          bad <= 1'b0;
        end
        DATA: begin
          // Shift in from the top so the first bit ends up in bit 0.
          shreg <= (shreg >> 1) | (DATA_W'(din) << (DATA_W - 1));
          cnt   <= cnt + 1'b1;
          acc   <= acc ^ din;
        end
        PARITY: if (din != acc) bad <= 1'b1;
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);

  serial_frame_obuf #(.W(DATA_W)) u_obuf (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_data    (shreg),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .overrun    (overrun)
  );

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx at DATA_W=8, even parity.
module tb_serial_frame_rx;
  import serial_frame_pkg::*;

  localparam int FLEN = frame_len(8, 1);

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       din = 1'b1;
  logic       dout_ready = 1'b1;
  logic [7:0] dout;
  logic       dout_valid, parity_err, framing_err, overrun, busy;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int rise_cyc [$];
  bit ovr_seen = 1'b0;
  bit perr_seen = 1'b0;
  bit prev_valid = 1'b0;

  serial_frame_rx #(.DATA_W(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .dout_ready  (dout_ready),
    .parity_err  (parity_err),
    .framing_err (framing_err),
    .overrun     (overrun),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Drive one bit for one clock, then settle 1ns after the edge.
  task automatic send_bit(input logic b);
    din = b;
    @(posedge clk);
    #1;
    cyc++;
    if (overrun) ovr_seen = 1'b1;
    if (parity_err) perr_seen = 1'b1;
    if (dout_valid && !prev_valid) rise_cyc.push_back(cyc);
    prev_valid = dout_valid;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(par);
    send_bit(stop);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    din = 1'b1;
    repeat (3) send_bit(1'b1);
    tests++;
    if (dout !== 8'h00 || dout_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs: dout=%h valid=%b busy=%b, want 00/0/0", dout, dout_valid, busy);
    end
    tests++;
    if (parity_err !== 1'b0 || framing_err !== 1'b0 || overrun !== 1'b0) begin
      fails++;
      $display("FAIL reset_pulses: perr=%b ferr=%b ovr=%b, want 0/0/0", parity_err, framing_err, overrun);
    end
    rst = 1'b1;
    send_bit(1'b1);
  endtask

  task automatic test_good_frame();
    logic [7:0] d;
    d = 8'hA5;
    dout_ready = 1'b1;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(1'b0);
    tests++;
    if (dout_valid !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL good_before_stop: valid=%b busy=%b, want 0/1", dout_valid, busy);
    end
    send_bit(1'b1);
    tests++;
    if (dout !== 8'hA5 || dout_valid !== 1'b1) begin
      fails++;
      $display("FAIL good_word: dout=%h valid=%b, want a5/1", dout, dout_valid);
    end
    tests++;
    if (parity_err !== 1'b0 || framing_err !== 1'b0 || overrun !== 1'b0) begin
      fails++;
      $display("FAIL good_no_err: perr=%b ferr=%b ovr=%b, want 0/0/0", parity_err, framing_err, overrun);
    end
    send_bit(1'b1);
    tests++;
    if (dout_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL good_handshake: valid=%b busy=%b, want 0/0", dout_valid, busy);
    end
  endtask

  task automatic test_parity_err();
    send_frame(8'hA5, 1'b1, 1'b1);
    tests++;
    if (parity_err !== 1'b1 || dout_valid !== 1'b0 || busy !== 1'b0 || framing_err !== 1'b0) begin
      fails++;
      $display("FAIL parity_pulse: perr=%b valid=%b busy=%b ferr=%b, want 1/0/0/0",
               parity_err, dout_valid, busy, framing_err);
    end
    send_bit(1'b1);
    tests++;
    if (parity_err !== 1'b0 || dout_valid !== 1'b0) begin
      fails++;
      $display("FAIL parity_one_cycle: perr=%b valid=%b, want 0/0", parity_err, dout_valid);
    end
  endtask

  task automatic test_overrun();
    dout_ready = 1'b0;
    send_frame(8'h3C, 1'b0, 1'b1);
    tests++;
    if (dout !== 8'h3C || dout_valid !== 1'b1 || overrun !== 1'b0) begin
      fails++;
      $display("FAIL ovr_first: dout=%h valid=%b ovr=%b, want 3c/1/0", dout, dout_valid, overrun);
    end
    send_frame(8'hC3, 1'b0, 1'b1);
    tests++;
    if (overrun !== 1'b1 || dout !== 8'h3C || dout_valid !== 1'b1) begin
      fails++;
      $display("FAIL ovr_pulse: ovr=%b dout=%h valid=%b, want 1/3c/1", overrun, dout, dout_valid);
    end
    send_bit(1'b1);
    tests++;
    if (overrun !== 1'b0 || dout_valid !== 1'b1) begin
      fails++;
      $display("FAIL ovr_one_cycle: ovr=%b valid=%b, want 0/1", overrun, dout_valid);
    end
    dout_ready = 1'b1;
    send_bit(1'b1);
    tests++;
    if (dout_valid !== 1'b0) begin
      fails++;
      $display("FAIL ovr_drain: valid=%b, want 0", dout_valid);
    end
  endtask

  task automatic test_framing();
    perr_seen = 1'b0;
    send_frame(8'h81, 1'b0, 1'b0);
    tests++;
    if (framing_err !== 1'b1 || parity_err !== 1'b0 || busy !== 1'b1 || dout_valid !== 1'b0) begin
      fails++;
      $display("FAIL frm_pulse: ferr=%b perr=%b busy=%b valid=%b, want 1/0/1/0",
               framing_err, parity_err, busy, dout_valid);
    end
    for (int i = 0; i < 5; i++) begin
      send_bit(1'b0);
      tests++;
      if (busy !== 1'b1 || framing_err !== 1'b0 || dout_valid !== 1'b0) begin
        fails++;
        $display("FAIL frm_resync[%0d]: busy=%b ferr=%b valid=%b, want 1/0/0", i, busy, framing_err, dout_valid);
      end
    end
    send_bit(1'b1);
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL frm_idle: busy=%b, want 0", busy);
    end
    repeat (FLEN) send_bit(1'b1);
    tests++;
    if (dout_valid !== 1'b0 || perr_seen !== 1'b0 || framing_err !== 1'b0) begin
      fails++;
      $display("FAIL frm_no_false_frame: valid=%b perr_seen=%b ferr=%b, want 0/0/0",
               dout_valid, perr_seen, framing_err);
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] d;
    d = 8'h77;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(d[i]);
    tests++;
    if (busy !== 1'b1 || dout !== 8'h3C) begin
      fails++;
      $display("FAIL mid_pre_reset: busy=%b dout=%h, want 1/3c", busy, dout);
    end
    rst = 1'b0;
    send_bit(d[4]);
    rst = 1'b1;
    tests++;
    if (dout !== 8'h00 || dout_valid !== 1'b0 || busy !== 1'b0 ||
        parity_err !== 1'b0 || framing_err !== 1'b0 || overrun !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset: dout=%h valid=%b busy=%b perr=%b ferr=%b ovr=%b, want all 0",
               dout, dout_valid, busy, parity_err, framing_err, overrun);
    end
    repeat (3) send_bit(1'b1);
    send_frame(8'h5A, 1'b0, 1'b1);
    tests++;
    if (dout !== 8'h5A || dout_valid !== 1'b1 || parity_err !== 1'b0) begin
      fails++;
      $display("FAIL mid_recover: dout=%h valid=%b perr=%b, want 5a/1/0", dout, dout_valid, parity_err);
    end
    send_bit(1'b1);
  endtask

  task automatic test_back_to_back();
    int base;
    dout_ready = 1'b1;
    ovr_seen = 1'b0;
    rise_cyc.delete();
    base = cyc;
    send_frame(8'h01, 1'b1, 1'b1);
    tests++;
    if (dout !== 8'h01 || dout_valid !== 1'b1) begin
      fails++;
      $display("FAIL b2b_first: dout=%h valid=%b, want 01/1", dout, dout_valid);
    end
    send_frame(8'hFF, 1'b0, 1'b1);
    tests++;
    if (dout !== 8'hFF || dout_valid !== 1'b1 || ovr_seen !== 1'b0) begin
      fails++;
      $display("FAIL b2b_second: dout=%h valid=%b ovr_seen=%b, want ff/1/0", dout, dout_valid, ovr_seen);
    end
    tests++;
    if (rise_cyc.size() != 2) begin
      fails++;
      $display("FAIL b2b_rises: count=%0d, want 2", rise_cyc.size());
    end else if (rise_cyc[0] - base != FLEN || rise_cyc[1] - base != 2 * FLEN) begin
      fails++;
      $display("FAIL b2b_latency: rises at %0d,%0d, want %0d,%0d",
               rise_cyc[0] - base, rise_cyc[1] - base, FLEN, 2 * FLEN);
    end
    send_bit(1'b1);
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_parity_err();
    test_overrun();
    test_framing();
    test_reset_midframe();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
